smart_mac_pe: RTL and testbench
===============================

Name: smart_mac_pe

Overview:
- Parametrised successor to the single-mode smart MAC processing element for the systolic array.
- Adds selectable dataflow: output-stationary (OS) or weight-stationary (WS).
- Adds a wide saturating accumulator, a per-PE weight register, and a valid/ready drain port for results.
- Keeps the smart-bus bypass muxing, so rows and columns can skip or feed PEs.

Parameters:
- WORD_SIZE, 16, operand/stream width (signed two's complement).
- ACC_WIDTH, 40, OS accumulator and result width; must be >= 2*WORD_SIZE.
- SAT_EN, 1, 1 = saturate on overflow, 0 = wrap.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mode_ws_in  in  1  0 = OS, 1 = WS; sampled only in IDLE on start_in
- start_in  in  1  IDLE -> COMPUTE
- load_weight_in  in  1  in IDLE, capture top_in_mux_out into weight register
- acc_clear_in  in  1  synchronous accumulator clear
- drain_in  in  1  OS: end of compute, go to DRAIN; WS: return to IDLE
- valid_in  in  1  left/top operands valid this cycle
- select_left_in_smart, select_top_in_smart  in  1 each  take operand from horizontal/vertical smart bus
- select_right_out_smart, select_bottom_out_smart  in  1 each  drive smart bus from right_out/bottom_out
- left_in, top_in  in  WORD_SIZE  systolic operands
- horizontal_smart_bus_in, vertical_smart_bus_in  in  WORD_SIZE  bypass buses
- right_out, bottom_out  out  WORD_SIZE  registered forwarded data
- right_valid_out, bottom_valid_out  out  1  registered valid_in
- horizontal_smart_bus_out, vertical_smart_bus_out  out  WORD_SIZE  bus pass/drive
- result_out  out  ACC_WIDTH  drained accumulator
- result_valid_out  out  1  result offered
- result_ready_in  in  1  consumer accepts result
- busy_out  out  1  high in COMPUTE and DRAIN
- err_out  out  1  sticky: valid_in seen in DRAIN, or overflow occurred

Behaviour:
- Reset (rst = 0, async): state IDLE, and all of the following clear to 0: right_out, bottom_out, valid outs, result_out, result_valid_out, busy_out, err_out, accumulator, weight.
- Input muxes (combinational):
  - left_in_mux_out = select_left_in_smart ? horizontal_smart_bus_in : left_in
  - top_in_mux_out is the same, using select_top_in_smart and the vertical bus.
- Bus outputs (combinational):
  - horizontal_smart_bus_out = select_right_out_smart ? right_out : horizontal_smart_bus_in
  - vertical_smart_bus_out is the same, using select_bottom_out_smart and bottom_out.
- States: IDLE, COMPUTE, DRAIN.
  - IDLE -> COMPUTE on start_in; latch the mode.
  - COMPUTE, OS mode, drain_in -> DRAIN.
  - COMPUTE, WS mode, drain_in -> IDLE.
  - DRAIN -> IDLE on result_valid_out && result_ready_in.
- Forwarding (all states, 1-cycle latency): when valid_in, right_out <= left_in_mux_out. right_valid_out <= valid_in every cycle. On !valid_in, the data registers hold.
- OS compute, on valid_in:
  - bottom_out <= top_in_mux_out.
  - acc <= acc + sext(left_in_mux_out * top_in_mux_out). The signed product is 2*WORD_SIZE wide.
  - On overflow: clamp to max/min if SAT_EN, else wrap; set err_out in either case.
- WS compute, on valid_in:
  - bottom_out <= top_in_mux_out + left_in_mux_out * weight, reduced to WORD_SIZE by saturation (SAT_EN) or truncation.
  - top is the incoming partial sum.
  - Overflow sets err_out.
- bottom_valid_out <= valid_in in COMPUTE (both modes), and in DRAIN as well, since forwarding continues in all states.
- DRAIN:
  - Entry cycle: result_out <= acc and result_valid_out <= 1.
  - result_out is held stable until handshake.
  - On handshake: acc <= 0, result_valid_out <= 0.
  - valid_in in DRAIN is still forwarded, not accumulated, and sets err_out.
- Priorities:
  - acc_clear_in with a valid beat: acc <= product (the clear applies first).
  - drain_in with valid_in: the beat is accumulated, then DRAIN is entered.
  - acc_clear_in is ignored in DRAIN.
- load_weight_in is honoured only in IDLE; elsewhere it is ignored.
- err_out clears only on reset, or on start_in in IDLE.
- Reset mid-DRAIN drops the offered result with no handshake.

Test Plan:
- OS, smart selects 0: start, 4 beats with left = 3 and top = -2, then drain -> result_out = -24, result_valid_out held until ready; acc = 0 afterwards; right_out tracks left with 1-cycle lag.
- WS: load weight 5 via top_in, start; left = 4, top = 10 -> bottom_out = 30 one cycle later, bottom_valid_out = 1.
- Saturation, WORD_SIZE = 16, WS: weight 32767, left = 2, top = 0 -> bottom_out = 32767, err_out = 1; with SAT_EN = 0 -> bottom_out = -2.
- Smart bus: select_left_in_smart = 1, horizontal bus = 7, left_in = 9 -> right_out = 7; select_right_out_smart = 0 -> horizontal_smart_bus_out equals bus input combinationally.
- Simultaneous: acc = 100, acc_clear_in + valid_in (6 * 7) -> acc = 42; drain_in with a valid beat -> beat included in the result.
- Backpressure/reset: result_ready_in low for 5 cycles -> result stable; assert rst low mid-DRAIN -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/smart_mac_pe.sv
// Systolic-array MAC processing element with output-stationary / weight-stationary dataflow,
// saturating accumulator, per-PE weight register and smart-bus bypass muxing.
module smart_mac_pe #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ACC_WIDTH = 40,
    parameter bit          SAT_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode_ws_in,
    input  logic                 start_in,
    input  logic                 load_weight_in,
    input  logic                 acc_clear_in,
    input  logic                 drain_in,
    input  logic                 valid_in,
    input  logic                 select_left_in_smart,
    input  logic                 select_top_in_smart,
    input  logic                 select_right_out_smart,
    input  logic                 select_bottom_out_smart,
    input  logic [WORD_SIZE-1:0] left_in,
    input  logic [WORD_SIZE-1:0] top_in,
    input  logic [WORD_SIZE-1:0] horizontal_smart_bus_in,
    input  logic [WORD_SIZE-1:0] vertical_smart_bus_in,
    output logic [WORD_SIZE-1:0] right_out,
    output logic [WORD_SIZE-1:0] bottom_out,
    output logic                 right_valid_out,
    output logic                 bottom_valid_out,
    output logic [WORD_SIZE-1:0] horizontal_smart_bus_out,
    output logic [WORD_SIZE-1:0] vertical_smart_bus_out,
    output logic [ACC_WIDTH-1:0] result_out,
    output logic                 result_valid_out,
    input  logic                 result_ready_in,
    output logic                 busy_out,
    output logic                 err_out
);
    localparam int unsigned PROD_W = 2 * WORD_SIZE;
    localparam int unsigned WSUM_W = PROD_W + 1;
    localparam int unsigned ASUM_W = ACC_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [WORD_SIZE-1:0] WORD_MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};
    localparam logic [WORD_SIZE-1:0] WORD_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_e;

    state_e                      state_q, state_d;
    logic                        mode_ws_q;
    logic signed [WORD_SIZE-1:0] weight_q;
    logic signed [ACC_WIDTH-1:0] acc_q;

    logic signed [WORD_SIZE-1:0] left_mux_c, top_mux_c;
    logic signed [PROD_W-1:0]    os_prod_c, ws_prod_c;
    logic signed [ASUM_W-1:0]    acc_sum_c;
    logic [ACC_WIDTH-1:0]        acc_upd_c;
    logic                        acc_ovf_c;
    logic signed [WSUM_W-1:0]    ws_sum_c;
    logic [WORD_SIZE+1:0]        ws_hi_c;
    logic                        ws_ovf_c;
    logic [WORD_SIZE-1:0]        ws_res_c;
    logic                        handshake_c;

    // Operand selection and bus pass-through / drive
    assign left_mux_c = select_left_in_smart ? horizontal_smart_bus_in : left_in;
    assign top_mux_c  = select_top_in_smart  ? vertical_smart_bus_in   : top_in;
    assign horizontal_smart_bus_out = select_right_out_smart  ? right_out  : horizontal_smart_bus_in;
    assign vertical_smart_bus_out   = select_bottom_out_smart ? bottom_out : vertical_smart_bus_in;

    // OS: one guard bit above the accumulator exposes signed overflow
    assign os_prod_c = PROD_W'(left_mux_c) * PROD_W'(top_mux_c);
    assign acc_sum_c = ASUM_W'(acc_q) + ASUM_W'(os_prod_c);
    assign acc_ovf_c = acc_sum_c[ACC_WIDTH] ^ acc_sum_c[ACC_WIDTH-1];
    assign acc_upd_c = (acc_ovf_c && SAT_EN) ? (acc_sum_c[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                                             : acc_sum_c[ACC_WIDTH-1:0];

    // WS: partial sum fits a word only if all bits above the word sign agree with it
    assign ws_prod_c = PROD_W'(left_mux_c) * PROD_W'(weight_q);
    assign ws_sum_c  = WSUM_W'(ws_prod_c) + WSUM_W'(top_mux_c);
    assign ws_hi_c   = ws_sum_c[PROD_W:WORD_SIZE-1];
    assign ws_ovf_c  = ~((&ws_hi_c) | ~(|ws_hi_c));
    assign ws_res_c  = (ws_ovf_c && SAT_EN) ? (ws_sum_c[WSUM_W-1] ? WORD_MIN : WORD_MAX)
                                            : ws_sum_c[WORD_SIZE-1:0];

    assign handshake_c = result_valid_out && result_ready_in;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_in)    state_d = COMPUTE;
            COMPUTE: if (drain_in)    state_d = mode_ws_q ? IDLE : DRAIN;
            DRAIN:   if (handshake_c) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            right_out        <= '0;
            bottom_out       <= '0;
            right_valid_out  <= 1'b0;
            bottom_valid_out <= 1'b0;
            result_out       <= '0;
            result_valid_out <= 1'b0;
            busy_out         <= 1'b0;
            err_out          <= 1'b0;
            mode_ws_q        <= 1'b0;
            weight_q         <= '0;
            acc_q            <= '0;
        end else begin
            right_valid_out  <= valid_in;
            bottom_valid_out <= valid_in;
            busy_out         <= (state_d != IDLE);
            if (valid_in) begin
                right_out  <= left_mux_c;
                bottom_out <= (state_q == COMPUTE && mode_ws_q) ? ws_res_c : top_mux_c;
            end
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        mode_ws_q <= mode_ws_in;
                        err_out   <= 1'b0;
                    end
                    if (load_weight_in) weight_q <= top_mux_c;
                    if (acc_clear_in)   acc_q    <= '0;
                end
                COMPUTE: begin
                    // A clear coinciding with a beat restarts the sum at that beat's product
                    if (acc_clear_in) begin
                        acc_q <= (valid_in && !mode_ws_q) ? ACC_WIDTH'(os_prod_c) : '0;
                    end else if (valid_in && !mode_ws_q) begin
                        acc_q <= acc_upd_c;
                    end
                    if (valid_in && (mode_ws_q ? ws_ovf_c : (acc_ovf_c && !acc_clear_in))) begin
                        err_out <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (valid_in) err_out <= 1'b1;
                    if (!result_valid_out) begin
                        result_out       <= acc_q;
                        result_valid_out <= 1'b1;
                    end else if (result_ready_in) begin
                        result_valid_out <= 1'b0;
                        acc_q            <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_smart_mac_pe.sv
// Scoreboard bench for smart_mac_pe: the driver pushes expected forwards/results from an
// arithmetic reference model; a negedge monitor pops and compares whenever outputs are valid.
module tb_smart_mac_pe;
    localparam int unsigned WS = 16;
    localparam int unsigned AW = 40;
    localparam int PH_IDLE = 0, PH_COMPUTE = 1, PH_DRAIN = 2;
    localparam longint W_MAX = 32767;
    localparam longint W_MIN = -32768;
    localparam longint A_MAX = (longint'(1) << (AW - 1)) - 1;
    localparam longint A_MIN = -A_MAX - 1;

    logic clk, rst;
    logic mode_ws_in, start_in, load_weight_in, acc_clear_in, drain_in, valid_in;
    logic select_left_in_smart, select_top_in_smart, select_right_out_smart, select_bottom_out_smart;
    logic [WS-1:0] left_in, top_in, horizontal_smart_bus_in, vertical_smart_bus_in;
    logic [WS-1:0] right_out, bottom_out, horizontal_smart_bus_out, vertical_smart_bus_out;
    logic right_valid_out, bottom_valid_out, result_valid_out, result_ready_in, busy_out, err_out;
    logic [AW-1:0] result_out;
    logic [WS-1:0] w_right_out, w_bottom_out, w_hbus_out, w_vbus_out;
    logic w_right_valid_out, w_bottom_valid_out, w_result_valid_out, w_busy_out, w_err_out;
    logic [AW-1:0] w_result_out;

    smart_mac_pe #(.WORD_SIZE(WS), .ACC_WIDTH(AW), .SAT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .mode_ws_in(mode_ws_in), .start_in(start_in),
        .load_weight_in(load_weight_in), .acc_clear_in(acc_clear_in), .drain_in(drain_in),
        .valid_in(valid_in), .select_left_in_smart(select_left_in_smart),
        .select_top_in_smart(select_top_in_smart), .select_right_out_smart(select_right_out_smart),
        .select_bottom_out_smart(select_bottom_out_smart), .left_in(left_in), .top_in(top_in),
        .horizontal_smart_bus_in(horizontal_smart_bus_in), .vertical_smart_bus_in(vertical_smart_bus_in),
        .right_out(right_out), .bottom_out(bottom_out), .right_valid_out(right_valid_out),
        .bottom_valid_out(bottom_valid_out), .horizontal_smart_bus_out(horizontal_smart_bus_out),
        .vertical_smart_bus_out(vertical_smart_bus_out), .result_out(result_out),
        .result_valid_out(result_valid_out), .result_ready_in(result_ready_in),
        .busy_out(busy_out), .err_out(err_out)
    );

    // Wrapping variant driven by identical stimulus
    smart_mac_pe #(.WORD_SIZE(WS), .ACC_WIDTH(AW), .SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .mode_ws_in(mode_ws_in), .start_in(start_in),
        .load_weight_in(load_weight_in), .acc_clear_in(acc_clear_in), .drain_in(drain_in),
        .valid_in(valid_in), .select_left_in_smart(select_left_in_smart),
        .select_top_in_smart(select_top_in_smart), .select_right_out_smart(select_right_out_smart),
        .select_bottom_out_smart(select_bottom_out_smart), .left_in(left_in), .top_in(top_in),
        .horizontal_smart_bus_in(horizontal_smart_bus_in), .vertical_smart_bus_in(vertical_smart_bus_in),
        .right_out(w_right_out), .bottom_out(w_bottom_out), .right_valid_out(w_right_valid_out),
        .bottom_valid_out(w_bottom_valid_out), .horizontal_smart_bus_out(w_hbus_out),
        .vertical_smart_bus_out(w_vbus_out), .result_out(w_result_out),
        .result_valid_out(w_result_valid_out), .result_ready_in(result_ready_in),
        .busy_out(w_busy_out), .err_out(w_err_out)
    );

    int checks = 0;
    int errors = 0;

    int                   m_phase = PH_IDLE;
    bit                   m_ws = 1'b0;
    bit                   m_err = 1'b0;
    logic signed [WS-1:0] m_weight = '0;
    logic signed [WS-1:0] m_right = '0;
    logic signed [WS-1:0] m_bottom = '0;
    longint               m_acc = 0;
    logic signed [WS-1:0] exp_right[$];
    logic signed [WS-1:0] exp_bottom[$];
    longint               exp_result[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start_in = 0; mode_ws_in = 0; load_weight_in = 0; acc_clear_in = 0;
        drain_in = 0; valid_in = 0; result_ready_in = 0;
        select_left_in_smart = 0; select_top_in_smart = 0;
        select_right_out_smart = 0; select_bottom_out_smart = 0;
        left_in = '0; top_in = '0;
        horizontal_smart_bus_in = WS'($urandom);
        vertical_smart_bus_in   = WS'($urandom);
    endtask

    // Apply the reference model to the inputs now on the pins, then advance one clock
    task automatic tick();
        logic signed [WS-1:0] lm, tm;
        longint s;
        lm = select_left_in_smart ? horizontal_smart_bus_in : left_in;
        tm = select_top_in_smart  ? vertical_smart_bus_in   : top_in;
        if (valid_in) begin
            m_right = lm;
            exp_right.push_back(lm);
            if (m_phase == PH_COMPUTE && m_ws) begin
                s = longint'(tm) + longint'(lm) * longint'(m_weight);
                if (s > W_MAX) begin m_err = 1; s = W_MAX; end
                if (s < W_MIN) begin m_err = 1; s = W_MIN; end
                m_bottom = WS'(s);
            end else begin
                m_bottom = tm;
            end
            exp_bottom.push_back(m_bottom);
            if (m_phase == PH_DRAIN) m_err = 1;
        end
        if (m_phase == PH_IDLE) begin
            if (load_weight_in) m_weight = tm;
            if (acc_clear_in) m_acc = 0;
            if (start_in) begin m_ws = mode_ws_in; m_err = 0; m_phase = PH_COMPUTE; end
        end else if (m_phase == PH_COMPUTE) begin
            if (acc_clear_in) begin
                m_acc = (valid_in && !m_ws) ? longint'(lm) * longint'(tm) : 0;
            end else if (valid_in && !m_ws) begin
                s = m_acc + longint'(lm) * longint'(tm);
                if (s > A_MAX) begin m_err = 1; s = A_MAX; end
                if (s < A_MIN) begin m_err = 1; s = A_MIN; end
                m_acc = s;
            end
            if (drain_in) begin
                if (m_ws) begin
                    m_phase = PH_IDLE;
                end else begin
                    exp_result.push_back(m_acc);
                    m_acc = 0;
                    m_phase = PH_DRAIN;
                end
            end
        end
        @(posedge clk);
        #1;
        check("busy_out", longint'(busy_out), longint'(m_phase != PH_IDLE));
        check("err_out", longint'(err_out), longint'(m_err));
    endtask

    task automatic wait_drain(input int hold);
        bit done = 1'b0;
        idle_inputs();
        for (int n = 0; n < 40 && !done; n++) begin
            result_ready_in = (n >= hold);
            @(negedge clk);
            done = result_valid_out && result_ready_in;
            if (done) m_phase = PH_IDLE;
            tick();
        end
        result_ready_in = 0;
        check("drain_handshake", longint'(done), 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_right_out", longint'(right_out), 0);
        check("rst_bottom_out", longint'(bottom_out), 0);
        check("rst_right_valid", longint'(right_valid_out), 0);
        check("rst_bottom_valid", longint'(bottom_valid_out), 0);
        check("rst_result_out", longint'(result_out), 0);
        check("rst_result_valid", longint'(result_valid_out), 0);
        check("rst_busy", longint'(busy_out), 0);
        check("rst_err", longint'(err_out), 0);
        check("rst_hbus_pass", longint'(horizontal_smart_bus_out), longint'(horizontal_smart_bus_in));
        check("rst_vbus_pass", longint'(vertical_smart_bus_out), longint'(vertical_smart_bus_in));
        check("rst_w_outs", longint'({w_right_out, w_bottom_out, w_right_valid_out, w_bottom_valid_out}), 0);
        check("rst_w_result", longint'({w_result_out, w_result_valid_out, w_busy_out, w_err_out}), 0);
        check("rst_w_buses", longint'({w_hbus_out, w_vbus_out}),
              longint'({horizontal_smart_bus_in, vertical_smart_bus_in}));
    endtask

    // Monitor: compare every presented output against the scoreboard
    initial forever begin
        @(negedge clk);
        if (right_valid_out) begin
            if (exp_right.size() == 0) check("right_extra", longint'(exp_right.size()), 1);
            else check("right_out", longint'($signed(right_out)), longint'(exp_right.pop_front()));
        end
        if (bottom_valid_out) begin
            if (exp_bottom.size() == 0) check("bottom_extra", longint'(exp_bottom.size()), 1);
            else check("bottom_out", longint'($signed(bottom_out)), longint'(exp_bottom.pop_front()));
        end
        if (result_valid_out) begin
            if (exp_result.size() == 0) begin
                check("result_extra", longint'(exp_result.size()), 1);
            end else begin
                check("result_out", longint'($signed(result_out)), exp_result[0]);
                if (result_ready_in) exp_result.delete(0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2 rst = 1'b0;
        #1 check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // OS: 4 beats of 3 * -2, drained with a 3-cycle ready delay
        idle_inputs(); start_in = 1; tick();
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); valid_in = 1; left_in = 16'd3; top_in = -16'sd2; tick();
        end
        idle_inputs(); drain_in = 1; tick();
        wait_drain(3);

        // WS: weight 5 loaded through top_in, 10 + 4 * 5
        idle_inputs(); load_weight_in = 1; top_in = 16'd5; tick();
        idle_inputs(); start_in = 1; mode_ws_in = 1; tick();
        idle_inputs(); valid_in = 1; left_in = 16'd4; top_in = 16'd10; tick();
        check("ws_bottom_valid", longint'(bottom_valid_out), 1);
        idle_inputs(); drain_in = 1; tick();

        // WS overflow: 0 + 2 * 32767 saturates here, wraps to -2 without saturation
        idle_inputs(); load_weight_in = 1; top_in = 16'h7FFF; tick();
        idle_inputs(); start_in = 1; mode_ws_in = 1; tick();
        idle_inputs(); valid_in = 1; left_in = 16'd2; top_in = 16'd0; tick();
        check("wrap_bottom", longint'($signed(w_bottom_out)), -2);
        check("wrap_err", longint'(w_err_out), 1);
        idle_inputs(); drain_in = 1; tick();

        // Smart bus operand select and bus drive/pass
        idle_inputs(); start_in = 1; tick();
        idle_inputs(); valid_in = 1; select_left_in_smart = 1;
        horizontal_smart_bus_in = 16'd7; left_in = 16'd9; top_in = 16'd1; tick();
        idle_inputs();
        #1 check("hbus_pass", longint'(horizontal_smart_bus_out), longint'(horizontal_smart_bus_in));
        select_right_out_smart = 1;
        #1 check("hbus_drive", longint'($signed(horizontal_smart_bus_out)), longint'(m_right));
        #1 check("vbus_pass", longint'(vertical_smart_bus_out), longint'(vertical_smart_bus_in));
        select_bottom_out_smart = 1;
        #1 check("vbus_drive", longint'($signed(vertical_smart_bus_out)), longint'(m_bottom));
        idle_inputs(); drain_in = 1; tick();
        wait_drain(0);

        // Clear with a beat, then drain with a beat
        idle_inputs(); start_in = 1; tick();
        idle_inputs(); valid_in = 1; left_in = 16'd10; top_in = 16'd10; tick();
        idle_inputs(); valid_in = 1; acc_clear_in = 1; left_in = 16'd6; top_in = 16'd7; tick();
        idle_inputs(); valid_in = 1; drain_in = 1; left_in = 16'd2; top_in = 16'd3; tick();
        wait_drain(1);

        // Randomized transactions in both dataflows
        for (int t = 0; t < 8; t++) begin
            idle_inputs(); load_weight_in = 1; top_in = WS'($urandom);
            select_top_in_smart = ($urandom_range(0, 1) == 1); tick();
            idle_inputs(); start_in = 1; mode_ws_in = ((t % 2) == 1); tick();
            for (int i = 0; i < 20; i++) begin
                idle_inputs();
                valid_in = ($urandom_range(0, 9) < 7);
                acc_clear_in = ($urandom_range(0, 19) == 0);
                left_in = WS'($urandom); top_in = WS'($urandom);
                select_left_in_smart = ($urandom_range(0, 3) == 0);
                select_top_in_smart  = ($urandom_range(0, 3) == 0);
                tick();
            end
            idle_inputs(); drain_in = 1; valid_in = ($urandom_range(0, 1) == 1);
            left_in = WS'($urandom); top_in = WS'($urandom); tick();
            if ((t % 2) == 0) wait_drain(int'($urandom_range(0, 3)));
        end

        // OS positive saturation: 520 beats of (-32768)^2 exceed the 40-bit range
        idle_inputs(); start_in = 1; tick();
        for (int i = 0; i < 520; i++) begin
            idle_inputs(); valid_in = 1; left_in = 16'h8000; top_in = 16'h8000; tick();
        end
        idle_inputs(); drain_in = 1; tick();
        wait_drain(0);

        // Backpressure with a beat during DRAIN, then asynchronous reset mid-DRAIN
        idle_inputs(); start_in = 1; tick();
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); valid_in = 1; left_in = WS'($urandom); top_in = WS'($urandom); tick();
        end
        idle_inputs(); drain_in = 1; tick();
        idle_inputs(); valid_in = 1; left_in = WS'($urandom); top_in = WS'($urandom); tick();
        for (int i = 0; i < 5; i++) begin
            idle_inputs(); tick();
        end
        check("bp_result_valid", longint'(result_valid_out), 1);
        #2 rst = 1'b0;
        exp_result.delete(); exp_right.delete(); exp_bottom.delete();
        m_phase = PH_IDLE; m_ws = 0; m_err = 0; m_weight = '0; m_acc = 0;
        #1 check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); tick();
        end

        check("exp_right_left", longint'(exp_right.size()), 0);
        check("exp_bottom_left", longint'(exp_bottom.size()), 0);
        check("exp_result_left", longint'(exp_result.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
